// File: rtl/rgb_led_pkg.sv
// Shared encodings for the RGB LED sequencer: program modes, colour phases
// and LED channel indices.
package rgb_led_pkg;

    localparam logic [1:0] MODE_STEP    = 2'b00;
    localparam logic [1:0] MODE_FADE    = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // R -> G -> B -> R; the unused encoding recovers to PH_R.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_R:    return PH_G;
            PH_G:    return PH_B;
            default: return PH_R;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Per-bit 2-FF synchroniser followed by a consecutive-mismatch debounce counter.
module sw_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [CW-1:0]    r_cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // The count only survives an unbroken run of mismatching cycles.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Switch-driven RGB LED controller: debounced run/mode select, phase/level
// sequencer, four lighting programs and a per-channel PWM output stage.
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PWM_BITS        = 8,
    parameter int STEP_CYCLES     = 12000,
    parameter bit LED_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    output logic [2:0] led
);

    localparam int PCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PCW-1:0]    PRESC_LAST = PCW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS:0] FULL       = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [2:0]        POL        = {3{LED_ACTIVE_LOW}};

    logic [2:0]          w_db;
    logic                w_run;
    logic [1:0]          w_mode;
    logic                w_restart;
    logic                w_tick;
    logic [PWM_BITS:0]   w_lvl_x;
    logic [PWM_BITS-1:0] w_tri;
    logic [PWM_BITS+1:0] w_breathe;
    logic [PWM_BITS:0]   w_duty [3];
    logic [2:0]          w_on;

    logic                r_run_q;
    logic [1:0]          r_mode_q;
    phase_t              r_phase;
    logic [PWM_BITS-1:0] r_lvl;
    logic [PCW-1:0]      r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic [2:0]          r_led;

    sw_debounce #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (sw),
        .o_db  (w_db)
    );

    assign w_run     = w_db[0];
    assign w_mode    = w_db[2:1];
    assign w_restart = (w_run && !r_run_q) || (w_mode != r_mode_q);
    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_lvl_x   = {1'b0, r_lvl};

    // Triangle: rises as 2*lvl in the lower half, falls as 2*(FULL-1-lvl) above.
    assign w_tri     = r_lvl[PWM_BITS-1] ? ~r_lvl : r_lvl;
    assign w_breathe = {1'b0, w_tri, 1'b0};

    always_comb begin
        for (int i = 0; i < 3; i++) w_duty[i] = '0;
        if (w_run) begin
            case (w_mode)
                MODE_STEP: begin
                    case (r_phase)
                        PH_G:    w_duty[CH_G] = FULL;
                        PH_B:    w_duty[CH_B] = FULL;
                        default: w_duty[CH_R] = FULL;
                    endcase
                end
                MODE_FADE: begin
                    case (r_phase)
                        PH_G: begin
                            w_duty[CH_G] = FULL - w_lvl_x;
                            w_duty[CH_B] = w_lvl_x;
                        end
                        PH_B: begin
                            w_duty[CH_B] = FULL - w_lvl_x;
                            w_duty[CH_R] = w_lvl_x;
                        end
                        default: begin
                            w_duty[CH_R] = FULL - w_lvl_x;
                            w_duty[CH_G] = w_lvl_x;
                        end
                    endcase
                end
                MODE_BLINK: begin
                    for (int i = 0; i < 3; i++)
                        w_duty[i] = r_lvl[PWM_BITS-1] ? '0 : FULL;
                end
                default: begin
                    for (int i = 0; i < 3; i++)
                        w_duty[i] = (w_breathe > {1'b0, FULL}) ? FULL
                                                               : w_breathe[PWM_BITS:0];
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) w_on[i] = ({1'b0, r_pwm} < w_duty[i]);
    end

    // Sequencer: OFF and restart both force PH_R/0/0; restart beats a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_q  <= 1'b0;
            r_mode_q <= MODE_STEP;
            r_phase  <= PH_R;
            r_lvl    <= '0;
            r_presc  <= '0;
            r_pwm    <= '0;
            r_led    <= POL;
        end else begin
            r_run_q  <= w_run;
            r_mode_q <= w_mode;
            r_pwm    <= r_pwm + 1'b1;
            r_led    <= w_on ^ POL;
            if (!w_run || w_restart) begin
                r_phase <= PH_R;
                r_lvl   <= '0;
                r_presc <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_lvl   <= r_lvl + 1'b1;
                if (&r_lvl) r_phase <= next_phase(r_phase);
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign led = r_led;

endmodule
